mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the unified 16-bit memory bus between the core memory controller and a debug/programming port.
//  Core owns the bus by default. A debug request pauses the core at a safe point
//  (its instruction-read state), then runs single-word debug accesses.
//  Bounded debug bursts, plus a pause timeout, keep either side from starving the other.
// PARAMETERS
//  MAX_BURST      4    max back-to-back debug accesses per pause (>=1)
//  PAUSE_TIMEOUT  15   cycles to wait for i_coreIdle before aborting the request (>=1)
//  TMR_W          4    timer width; must hold PAUSE_TIMEOUT
// PORTS
//  i_clk        in   1   clock; all state updates on rising edge
//  i_rst        in   1   reset, synchronous, active-high
//  i_coreAddr   in   16  core memory-controller address (bit15 = data section)
//  i_coreWdata  in   16  core write data
//  i_coreWr     in   1   core write strobe
//  i_coreIdle   in   1   core is in its instruction-read state (safe pause point)
//  o_corePause  out  1   hold core; core freezes while in instruction-read state
//  i_dbgReq     in   1   debug access request (level)
//  i_dbgAddr    in   16  debug address
//  i_dbgWr      in   1   1 = write, 0 = read
//  i_dbgWdata   in   16  debug write data
//  o_dbgRdata   out  16  debug read data; valid while o_dbgDone=1, held afterwards
//  o_dbgDone    out  1   one-cycle pulse: access complete
//  o_dbgErr     out  1   one-cycle pulse: pause timed out, request dropped
//  o_dbgOwns    out  1   debug port drives memory bus this cycle
//  o_memAddr    out  16  memory address
//  o_memWdata   out  16  memory write data
//  o_memWr      out  1   memory write enable
//  i_memRdata   in   16  memory read data; valid 1 cycle after address
// BEHAVIOUR
//  Clock and reset: one clock (i_clk); synchronous active-high reset (i_rst).
//  Reset: state=CORE, timer=0, burst=0, o_dbgRdata=0. Outputs: pause/done/err/owns=0.
//  Reset mid-access aborts the access with no done/err pulse.
//  Bus mux: o_dbgOwns=1 only in XFER and RESP. Then mem* = dbg*, with o_memWr=i_dbgWr in XFER, 0 in RESP.
//   Otherwise mem* = core* (pass-through, combinational).
//  FSM (3-bit, registered state, Moore outputs):
//   CORE    pause=0. i_dbgReq=1 -> PAUSING, timer=0.
//   PAUSING pause=1; core still owns bus. Transitions:
//           i_dbgReq=0 -> CORE (abort, no pulse).
//           else i_coreIdle=1 -> XFER.
//           else timer==PAUSE_TIMEOUT-1 -> CORE, o_dbgErr pulses in the CORE cycle.
//           else timer++.
//   XFER    pause=1; debug access on bus (write commits this cycle) -> RESP.
//   RESP    pause=1; o_dbgRdata<=i_memRdata (reads and writes), o_dbgDone=1; burst++ -> NEXT.
//   NEXT    pause=1; bus to core (core frozen). Transitions:
//           i_dbgReq=1 && burst<MAX_BURST -> XFER.
//           else -> CORE, burst=0.
//  Handshake: requester holds addr/wr/wdata/req stable from req rise until done.
//   In the cycle after done (NEXT), it drops req or presents the next access.
//  Latency: req rise to done = 4 cycles with i_coreIdle already 1
//   (CORE, PAUSING, XFER, RESP). Burst accesses repeat every 3 cycles.
//  Fairness: after MAX_BURST accesses the core gets >=1 cycle with pause=0 (CORE state).
//   A still-high req then re-enters PAUSING.
//  err and done never pulse in the same cycle. Timer saturates; it never wraps.
//  i_coreIdle is ignored outside PAUSING.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds o_dbgCount[15:0].
//   Saturating count of completed debug accesses (+1 per done) and i_rst clears it.
//  Undefined: port absent, no counter logic.
// TESTING
//  Reset: i_rst=1 1 cycle -> all outputs 0. Core addr 0x8012 appears on o_memAddr.
//  Single write: i_coreIdle=1, req wr addr=0x0040 data=0xBEEF.
//   -> o_memWr=1, o_memAddr=0x0040 on cycle 3; done on cycle 4.
//  Burst read: req held for 6 reads, MAX_BURST=4 -> 4 dones.
//   Then 1 cycle pause=0, re-pause, 2 more dones.
//  Timeout: i_coreIdle=0, req=1 -> err pulse after 15 PAUSING cycles. No mem access; pause drops.
//  Abort: req drops in PAUSING -> back to CORE next cycle, no done/err.
//   Mid-XFER i_rst -> CORE, no done.
//  Stats (MEM_ARB_STATS_EN): 0xFFFF+ accesses -> o_dbgCount holds 0xFFFF.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the 16-bit memory bus between the core memory
// controller and a debug/programming port. The core owns the bus by default.
// A debug request pauses the core at its instruction-read state and then runs
// single-word debug accesses. Bursts are bounded by MAX_BURST and pausing is
// bounded by PAUSE_TIMEOUT, so neither side can starve the other.
// Optional build macro MEM_ARB_STATS_EN adds o_dbgCount, a saturating count
// of completed debug accesses.
module mem_bus_arbiter #(
    parameter int MAX_BURST     = 4,
    parameter int PAUSE_TIMEOUT = 15,
    parameter int TMR_W         = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_coreAddr,
    input  logic [15:0] i_coreWdata,
    input  logic        i_coreWr,
    input  logic        i_coreIdle,
    output logic        o_corePause,
    input  logic        i_dbgReq,
    input  logic [15:0] i_dbgAddr,
    input  logic        i_dbgWr,
    input  logic [15:0] i_dbgWdata,
    output logic [15:0] o_dbgRdata,
    output logic        o_dbgDone,
    output logic        o_dbgErr,
    output logic        o_dbgOwns,
    output logic [15:0] o_memAddr,
    output logic [15:0] o_memWdata,
    output logic        o_memWr,
    input  logic [15:0] i_memRdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] o_dbgCount
`endif
);

    localparam int               BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(PAUSE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    typedef enum logic [2:0] {
        ST_CORE    = 3'd0,
        ST_PAUSING = 3'd1,
        ST_XFER    = 3'd2,
        ST_RESP    = 3'd3,
        ST_NEXT    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    // Next-state logic: pause handshake, timeout, bounded burst, read capture.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        timer_d = timer_q;
        burst_d = burst_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_CORE: begin
                if (i_dbgReq) begin
                    state_d = ST_PAUSING;
                    timer_d = '0;
                end
            end
            ST_PAUSING: begin
                if (!i_dbgReq) begin
                    state_d = ST_CORE;
                end else if (i_coreIdle) begin
                    state_d = ST_XFER;
                end else if (timer_q == TMR_LAST) begin
                    // Error flag is registered so it pulses in the CORE cycle.
                    state_d = ST_CORE;
                    err_d   = 1'b1;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_XFER: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rdata_d = i_memRdata;
                if (burst_q < BURST_LIM) begin
                    burst_d = burst_q + 1'b1;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (i_dbgReq && (burst_q < BURST_LIM)) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_CORE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = ST_CORE;
                burst_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value, independent of statement order.
        if (i_rst) begin
            state_q <= ST_CORE;
            timer_q <= '0;
            burst_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            burst_q <= burst_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Moore status outputs and the combinational bus multiplexer.
    always_comb begin
        o_corePause = (state_q != ST_CORE);
        o_dbgOwns   = (state_q == ST_XFER) || (state_q == ST_RESP);
        o_dbgDone   = (state_q == ST_RESP);
        o_dbgErr    = err_q;
        // Read data arrives during RESP; forward it so it is valid alongside
        // done, and the capture register holds it afterwards.
        o_dbgRdata  = (state_q == ST_RESP) ? i_memRdata : rdata_q;
        if (o_dbgOwns) begin
            o_memAddr  = i_dbgAddr;
            o_memWdata = i_dbgWdata;
            o_memWr    = (state_q == ST_XFER) ? i_dbgWr : 1'b0;
        end else begin
            o_memAddr  = i_coreAddr;
            o_memWdata = i_coreWdata;
            o_memWr    = i_coreWr;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] count_q, count_d;

    // Saturating count of completed debug accesses.
    always_comb begin
        count_d = count_q;
        if ((state_q == ST_RESP) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Access counter register, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_dbgCount = count_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a per-cycle vector table for reset,
// core pass-through and a single debug write, then hand-written sequences for
// burst fairness, pause timeout, abort and reset during a transfer.
module tb_mem_bus_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_coreAddr;
    logic [15:0] i_coreWdata;
    logic        i_coreWr;
    logic        i_coreIdle;
    logic        o_corePause;
    logic        i_dbgReq;
    logic [15:0] i_dbgAddr;
    logic        i_dbgWr;
    logic [15:0] i_dbgWdata;
    logic [15:0] o_dbgRdata;
    logic        o_dbgDone;
    logic        o_dbgErr;
    logic        o_dbgOwns;
    logic [15:0] o_memAddr;
    logic [15:0] o_memWdata;
    logic        o_memWr;
    logic [15:0] i_memRdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] o_dbgCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(
        .MAX_BURST    (4),
        .PAUSE_TIMEOUT(15),
        .TMR_W        (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_coreAddr (i_coreAddr),
        .i_coreWdata(i_coreWdata),
        .i_coreWr   (i_coreWr),
        .i_coreIdle (i_coreIdle),
        .o_corePause(o_corePause),
        .i_dbgReq   (i_dbgReq),
        .i_dbgAddr  (i_dbgAddr),
        .i_dbgWr    (i_dbgWr),
        .i_dbgWdata (i_dbgWdata),
        .o_dbgRdata (o_dbgRdata),
        .o_dbgDone  (o_dbgDone),
        .o_dbgErr   (o_dbgErr),
        .o_dbgOwns  (o_dbgOwns),
        .o_memAddr  (o_memAddr),
        .o_memWdata (o_memWdata),
        .o_memWr    (o_memWr),
        .i_memRdata (i_memRdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .o_dbgCount (o_dbgCount)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory model: write on the edge, read data valid one cycle after address.
    logic [15:0] mem [256];

    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a * 16'd257) ^ 16'hC3A5;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = pat(16'(i));
    end

    always @(posedge i_clk) begin
        if (o_memWr) mem[o_memAddr[7:0]] <= o_memWdata;
        i_memRdata <= mem[o_memAddr[7:0]];
    end

    // done and err must never coincide.
    bit both_seen = 1'b0;
    always @(negedge i_clk) if (o_dbgDone === 1'b1 && o_dbgErr === 1'b1) both_seen = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic        idle;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] core_addr;
        logic [15:0] core_wdata;
        logic        core_wr;
        logic        exp_pause;
        logic        exp_owns;
        logic        exp_mem_wr;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Core pass-through, then a single debug write CORE->PAUSING->XFER->RESP->NEXT->CORE.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b1,
                    1'b0, 1'b0, 1'b1, 16'h8012, 16'h1234, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 16'h0003, 16'hFFFF, 1'b0,
                    1'b0, 1'b0, 1'b0, 16'h0003, 16'hFFFF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b0,
                    1'b0, 1'b0, 1'b0, 16'h8012, 16'h1234, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b0,
                    1'b1, 1'b0, 1'b0, 16'h8012, 16'h1234, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b0,
                    1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b0,
                    1'b1, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b0,
                    1'b1, 1'b0, 1'b0, 16'h8012, 16'h1234, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h8012, 16'h1234, 1'b0,
                    1'b0, 1'b0, 1'b0, 16'h8012, 16'h1234, 1'b0, 1'b0};

        // ---------------- reset ----------------
        i_rst = 1'b1;
        i_coreAddr = 16'h8012; i_coreWdata = 16'h1234; i_coreWr = 1'b0; i_coreIdle = 1'b1;
        i_dbgReq = 1'b0; i_dbgAddr = 16'h0000; i_dbgWr = 1'b0; i_dbgWdata = 16'h0000;
        next_cycle();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_pause", o_corePause, 0);
        check("reset_done", o_dbgDone, 0);
        check("reset_err", o_dbgErr, 0);
        check("reset_owns", o_dbgOwns, 0);
        check("reset_rdata", o_dbgRdata, 0);
        check("reset_memaddr", o_memAddr, 16'h8012);

        // ---------------- vector table ----------------
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            i_dbgReq = vecs[i].req; i_coreIdle = vecs[i].idle; i_dbgWr = vecs[i].wr;
            i_dbgAddr = vecs[i].addr; i_dbgWdata = vecs[i].wdata;
            i_coreAddr = vecs[i].core_addr; i_coreWdata = vecs[i].core_wdata;
            i_coreWr = vecs[i].core_wr;
            @(negedge i_clk);
            check($sformatf("vec%0d_pause", i), o_corePause, vecs[i].exp_pause);
            check($sformatf("vec%0d_owns", i), o_dbgOwns, vecs[i].exp_owns);
            check($sformatf("vec%0d_memwr", i), o_memWr, vecs[i].exp_mem_wr);
            check($sformatf("vec%0d_memaddr", i), o_memAddr, vecs[i].exp_addr);
            check($sformatf("vec%0d_memwdata", i), o_memWdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d_done", i), o_dbgDone, vecs[i].exp_done);
            check($sformatf("vec%0d_err", i), o_dbgErr, vecs[i].exp_err);
        end
        check("write_committed", mem[8'h40], 16'hBEEF);

        // ---------------- burst of 6 reads, MAX_BURST=4 ----------------
        begin
            int  dn = 0;
            int  last_c = 0;
            int  first_c = -1;
            int  plow = 0;
            bit  got = 1'b0;
            bit  burst_bad = 1'b0;
            next_cycle();
            i_coreIdle = 1'b1; i_dbgWr = 1'b0; i_dbgAddr = 16'h0020; i_dbgReq = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(negedge i_clk);
                if (o_memWr || o_dbgErr) burst_bad = 1'b1;
                if (dn > 0 && !o_corePause) plow++;
                if (o_dbgDone) begin
                    check($sformatf("burst_rdata%0d", dn), o_dbgRdata, pat(16'h0020 + 16'(dn)));
                    if (dn == 0) first_c = c;
                    else check($sformatf("burst_gap%0d", dn), c - last_c, (dn == 4) ? 5 : 3);
                    last_c = c;
                    dn++;
                    got = 1'b1;
                end
                next_cycle();
                if (got) begin
                    got = 1'b0;
                    if (dn == 6) begin
                        i_dbgReq = 1'b0;
                        break;
                    end
                    i_dbgAddr = 16'h0020 + 16'(dn);
                end
            end
            check("burst_done_count", dn, 6);
            check("burst_first_latency", first_c, 3);
            check("burst_core_window", plow, 1);
            check("burst_no_write_or_err", burst_bad, 0);
            @(negedge i_clk);
            check("burst_next_pause", o_corePause, 1);
            check("burst_rdata_held", o_dbgRdata, pat(16'h0025));
            next_cycle();
            @(negedge i_clk);
            check("burst_end_pause", o_corePause, 0);
`ifdef MEM_ARB_STATS_EN
            check("stats_count", o_dbgCount, 7);
`endif
        end

        // ---------------- pause timeout ----------------
        begin
            int pcyc = 0;
            bit saw_err = 1'b0;
            bit bad_bus = 1'b0;
            next_cycle();
            i_coreIdle = 1'b0; i_dbgReq = 1'b1; i_dbgAddr = 16'h0030; i_dbgWr = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge i_clk);
                if (o_dbgOwns || o_memWr || o_dbgDone) bad_bus = 1'b1;
                if (o_dbgErr) begin
                    saw_err = 1'b1;
                    check("timeout_err_pause", o_corePause, 0);
                    break;
                end
                if (o_corePause) pcyc++;
                next_cycle();
            end
            check("timeout_err_seen", saw_err, 1);
            check("timeout_pause_cycles", pcyc, 15);
            check("timeout_no_bus", bad_bus, 0);
            next_cycle();
            i_dbgReq = 1'b0;
            @(negedge i_clk);
            check("timeout_err_one_cycle", o_dbgErr, 0);
            next_cycle();
            @(negedge i_clk);
            check("timeout_idle_after", o_corePause, 0);
        end

        // ---------------- abort in PAUSING ----------------
        begin
            bit stray = 1'b0;
            next_cycle();
            i_coreIdle = 1'b0; i_dbgReq = 1'b1; i_dbgWr = 1'b0;
            next_cycle();
            next_cycle();
            i_dbgReq = 1'b0;
            @(negedge i_clk);
            check("abort_still_pausing", o_corePause, 1);
            next_cycle();
            @(negedge i_clk);
            check("abort_pause_dropped", o_corePause, 0);
            for (int c = 0; c < 20; c++) begin
                next_cycle();
                @(negedge i_clk);
                if (o_dbgErr || o_dbgDone || o_corePause) stray = 1'b1;
            end
            check("abort_no_pulse", stray, 0);
        end

        // ---------------- reset during XFER ----------------
        begin
            bit stray = 1'b0;
            next_cycle();
            i_coreIdle = 1'b1; i_dbgReq = 1'b1; i_dbgWr = 1'b1;
            i_dbgAddr = 16'h0041; i_dbgWdata = 16'h1111;
            next_cycle();
            next_cycle();
            i_rst = 1'b1;
            @(negedge i_clk);
            check("rst_xfer_owns", o_dbgOwns, 1);
            next_cycle();
            i_rst = 1'b0;
            i_dbgReq = 1'b0;
            @(negedge i_clk);
            check("rst_xfer_pause", o_corePause, 0);
            check("rst_xfer_owns_after", o_dbgOwns, 0);
            check("rst_xfer_rdata", o_dbgRdata, 0);
            for (int c = 0; c < 4; c++) begin
                if (o_dbgDone || o_dbgErr) stray = 1'b1;
                next_cycle();
                @(negedge i_clk);
            end
            check("rst_xfer_no_pulse", stray, 0);
        end

        check("done_err_exclusive", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
